bcd_scan_display: RTL and testbench

- Consumer end of the two-digit BCD count interface: takes tens/units BCD digits (00..99) from the counter and drives a time-multiplexed two-digit seven-segment display.
- Snapshots both digits once per scan frame so the two displayed digits always come from the same count value.
- Sits between the BCD counter and the board display pins.

---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/bcd_scan_display.sv | 91 +++++++++
 tb/tb_bcd_scan_display.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the two-digit BCD scan display.
// Seven-segment codes are active-high, bit 0 = segment a .. bit 6 = segment g.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_EN_UNITS = 2'b01;
    localparam logic [1:0] DIG_EN_TENS  = 2'b10;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } digit_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment encoder; codes 10..15 show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed two-digit seven-segment driver with per-frame digit snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] in1,
    input  logic [3:0] in0,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_done
);

    localparam int DIV_W = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] TC_VAL   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] prescaler;
    logic             tc;
    digit_state_t     state;
    digit_state_t     next_state;
    logic [3:0]       snap_tens;
    logic [3:0]       next_snap_tens;
    logic [6:0]       next_seg;
    logic [1:0]       next_dig_en;
    logic             next_frame_done;
    logic [3:0]       enc_in;
    logic [6:0]       enc_seg;
    logic [6:0]       tens_seg;

    assign tc = (prescaler == TC_VAL);

    // One encoder serves both digits: it sees the digit about to be lit.
    assign enc_in = (state == DIG0) ? snap_tens : in0;

    bcd_to_seg7 u_enc (
        .bcd (enc_in),
        .seg (enc_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign tens_seg = (snap_tens == 4'd0) ? SEG_BLANK : enc_seg;
`else
    assign tens_seg = enc_seg;
`endif

    // The units snapshot lives in the seg register itself, so only tens is stored.
    always_comb begin
        next_state      = state;
        next_snap_tens  = snap_tens;
        next_seg        = seg;
        next_dig_en     = dig_en;
        next_frame_done = 1'b0;
        if (tc) begin
            if (state == DIG0) begin
                next_state  = DIG1;
                next_dig_en = DIG_EN_TENS;
                next_seg    = tens_seg;
            end else begin
                next_state      = DIG0;
                next_snap_tens  = in1;
                next_dig_en     = DIG_EN_UNITS;
                next_seg        = enc_seg;
                next_frame_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescaler  <= '0;
            state      <= DIG0;
            snap_tens  <= 4'd0;
            seg        <= SEG_0;
            dig_en     <= DIG_EN_UNITS;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= tc ? '0 : prescaler + DIV_ONE;
            state      <= next_state;
            snap_tens  <= next_snap_tens;
            seg        <= next_seg;
            dig_en     <= next_dig_en;
            frame_done <= next_frame_done;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed, table-driven bench for bcd_scan_display at SCAN_DIV=4.
// Honors LEADING_ZERO_BLANK_EN when computing the expected zero-tens code.
module tb_bcd_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    logic       clk;
    logic       resetn;
    logic [3:0] in1;
    logic [3:0] in0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_done;

    int checks;
    int failures;

    typedef struct {
        logic       resetn;
        logic [3:0] in1;
        logic [3:0] in0;
        logic [6:0] seg;
        logic [1:0] dig_en;
        logic       frame_done;
    } vec_t;

    vec_t vecs[$];

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in1        (in1),
        .in0        (in0),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_run(input int n, input logic rn, input logic [3:0] t, input logic [3:0] u,
                           input logic [6:0] s, input logic [1:0] e, input logic f);
        vec_t v;
        v.resetn = rn; v.in1 = t; v.in0 = u;
        v.seg = s; v.dig_en = e; v.frame_done = f;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic rn, input logic [3:0] t, input logic [3:0] u);
        resetn = rn;
        in1    = t;
        in0    = u;
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, actual, expected);
        end
    endtask

    initial begin
        int cycles;
        checks   = 0;
        failures = 0;
        apply_stimulus(1'b0, 4'd4, 4'd2);

        // Reset hold, then one frame per block (4 cycles units, 4 cycles tens).
        add_run(10, 1'b0, 4'd4, 4'd2,  7'h3F,     2'b01, 1'b0);
        add_run(3,  1'b1, 4'd4, 4'd2,  7'h3F,     2'b01, 1'b0);
        add_run(4,  1'b1, 4'd4, 4'd2,  TENS_ZERO, 2'b10, 1'b0);
        add_run(1,  1'b1, 4'd4, 4'd2,  7'h5B,     2'b01, 1'b1);
        add_run(3,  1'b1, 4'd4, 4'd2,  7'h5B,     2'b01, 1'b0);
        add_run(1,  1'b1, 4'd4, 4'd2,  7'h66,     2'b10, 1'b0);
        add_run(3,  1'b1, 4'd1, 4'd12, 7'h66,     2'b10, 1'b0);
        add_run(1,  1'b1, 4'd1, 4'd12, 7'h40,     2'b01, 1'b1);
        add_run(3,  1'b1, 4'd1, 4'd12, 7'h40,     2'b01, 1'b0);
        add_run(4,  1'b1, 4'd1, 4'd12, 7'h06,     2'b10, 1'b0);
        add_run(1,  1'b1, 4'd3, 4'd9,  7'h6F,     2'b01, 1'b1);
        add_run(1,  1'b1, 4'd3, 4'd9,  7'h6F,     2'b01, 1'b0);
        add_run(2,  1'b1, 4'd4, 4'd0,  7'h6F,     2'b01, 1'b0);
        add_run(4,  1'b1, 4'd4, 4'd0,  7'h4F,     2'b10, 1'b0);
        add_run(1,  1'b1, 4'd4, 4'd0,  7'h3F,     2'b01, 1'b1);
        add_run(3,  1'b1, 4'd4, 4'd0,  7'h3F,     2'b01, 1'b0);
        add_run(4,  1'b1, 4'd4, 4'd0,  7'h66,     2'b10, 1'b0);
        add_run(1,  1'b1, 4'd0, 4'd7,  7'h07,     2'b01, 1'b1);
        add_run(3,  1'b1, 4'd0, 4'd7,  7'h07,     2'b01, 1'b0);
        add_run(4,  1'b1, 4'd0, 4'd7,  TENS_ZERO, 2'b10, 1'b0);
        add_run(1,  1'b1, 4'd0, 4'd7,  7'h07,     2'b01, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].resetn, vecs[i].in1, vecs[i].in0);
            step();
            check_output("seg",        i, {1'b0, seg},        {1'b0, vecs[i].seg});
            check_output("dig_en",     i, {6'd0, dig_en},     {6'd0, vecs[i].dig_en});
            check_output("frame_done", i, {7'd0, frame_done}, {7'd0, vecs[i].frame_done});
        end

        // Mid-operation reset: reach DIG1 with prescaler at 2, then pull resetn.
        for (int i = 0; i < 6; i++) step();
        check_output("pre_reset_dig_en", 0, {6'd0, dig_en}, 8'h02);
        apply_stimulus(1'b0, 4'd0, 4'd7);
        step();
        check_output("midrst_seg",        0, {1'b0, seg},        8'h3F);
        check_output("midrst_dig_en",     0, {6'd0, dig_en},     8'h01);
        check_output("midrst_frame_done", 0, {7'd0, frame_done}, 8'h00);
        step();
        apply_stimulus(1'b1, 4'd0, 4'd7);

        cycles = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (frame_done === 1'b1) begin
                cycles = n;
                break;
            end
        end
        check_output("first_frame_latency", 0, 8'(cycles), 8'd8);
        check_output("post_rst_units_seg",  0, {1'b0, seg}, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
